// File: rtl/rice_run_scheduler.sv
// rice_run_scheduler: sequences JPEG-LS run-mode commands for the Rice encoder.
// Tracks the run counter and RUNindex from per-pixel classification flags.
// Each accepted pixel produces at most one registered encoder command.
module rice_run_scheduler #(
    parameter int J_length        = 5,
    parameter int runcount_length = 16,
    parameter int mode_length     = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_start,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic                       s_run_ctx,
    input  logic                       s_run_match,
    input  logic                       s_eol,
    input  logic                       s_RIType,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [mode_length-1:0]     mode,
    output logic                       hit,
    output logic [3:0]                 J,
    output logic [3:0]                 J_Comp,
    output logic [runcount_length-1:0] run_length,
    output logic                       RIType,
    output logic                       do_run_encoding,
    output logic [J_length-1:0]        run_index
);

    typedef enum logic [0:0] {
        ST_REGULAR = 1'b0,
        ST_RUN     = 1'b1
    } state_e;

    localparam logic [mode_length-1:0]     MODE_REGULAR = 2'd0;
    localparam logic [mode_length-1:0]     MODE_HIT     = 2'd1;
    localparam logic [mode_length-1:0]     MODE_INTR    = 2'd2;
    localparam logic [mode_length-1:0]     MODE_EOL     = 2'd3;
    localparam logic [J_length-1:0]        IDX_ZERO     = {J_length{1'b0}};
    localparam logic [J_length-1:0]        IDX_ONE      = {{(J_length-1){1'b0}}, 1'b1};
    localparam logic [J_length-1:0]        IDX_MAX      = {J_length{1'b1}};
    localparam logic [runcount_length-1:0] CNT_ZERO     = {runcount_length{1'b0}};
    localparam logic [runcount_length-1:0] CNT_ONE      = {{(runcount_length-1){1'b0}}, 1'b1};

    // Fixed JPEG-LS J table: run-length order for each RUNindex.
    function automatic logic [3:0] j_lookup(input logic [J_length-1:0] idx);
        logic [3:0] j_v;
        case (idx)
            5'd0, 5'd1, 5'd2, 5'd3:     j_v = 4'd0;
            5'd4, 5'd5, 5'd6, 5'd7:     j_v = 4'd1;
            5'd8, 5'd9, 5'd10, 5'd11:   j_v = 4'd2;
            5'd12, 5'd13, 5'd14, 5'd15: j_v = 4'd3;
            5'd16, 5'd17:               j_v = 4'd4;
            5'd18, 5'd19:               j_v = 4'd5;
            5'd20, 5'd21:               j_v = 4'd6;
            5'd22, 5'd23:               j_v = 4'd7;
            5'd24:                      j_v = 4'd8;
            5'd25:                      j_v = 4'd9;
            5'd26:                      j_v = 4'd10;
            5'd27:                      j_v = 4'd11;
            5'd28:                      j_v = 4'd12;
            5'd29:                      j_v = 4'd13;
            5'd30:                      j_v = 4'd14;
            5'd31:                      j_v = 4'd15;
            default:                    j_v = 4'd0;
        endcase
        return j_v;
    endfunction

    state_e                       state_q, state_d;
    logic [J_length-1:0]          idx_q, idx_d;
    logic [runcount_length-1:0]   cnt_q, cnt_d;
    logic                         valid_q, valid_d;
    logic [mode_length-1:0]       mode_q, mode_d;
    logic                         hit_q, hit_d;
    logic [3:0]                   j_q, j_d;
    logic [3:0]                   jcomp_q, jcomp_d;
    logic [runcount_length-1:0]   rl_q, rl_d;
    logic                         rit_q, rit_d;
    logic                         dre_q, dre_d;

    logic                         accept_s;
    logic [3:0]                   j_cur_s;
    logic [runcount_length-1:0]   cnt_next_s;
    logic [runcount_length-1:0]   thresh_s;
    logic                         run_path_s;
    logic                         hit_now_s;
    logic                         issue_s;
    logic [mode_length-1:0]       cmd_mode_s;
    logic [3:0]                   cmd_j_s;
    logic [3:0]                   cmd_jcomp_s;
    logic [runcount_length-1:0]   cmd_rl_s;
    logic                         cmd_rit_s;

    // A new pixel can be taken whenever the command slot is free or draining.
    assign s_ready    = !valid_q || m_ready;
    assign accept_s   = s_valid && s_ready;
    assign j_cur_s    = j_lookup(idx_q);
    assign cnt_next_s = cnt_q + CNT_ONE;
    assign thresh_s   = CNT_ONE << j_cur_s;

    // Pixel decision: next run state and the command (if any) this pixel produces.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        run_path_s  = 1'b0;
        hit_now_s   = 1'b0;
        issue_s     = 1'b0;
        cmd_mode_s  = MODE_REGULAR;
        cmd_j_s     = 4'd0;
        cmd_jcomp_s = 4'd0;
        cmd_rl_s    = CNT_ZERO;
        cmd_rit_s   = 1'b0;
        if (frame_start) begin
            // Frame boundary wins over any handshake; the pixel is dropped.
            state_d = ST_REGULAR;
            idx_d   = IDX_ZERO;
            cnt_d   = CNT_ZERO;
        end else if (accept_s) begin
            case (state_q)
                ST_REGULAR: begin
                    if (s_run_ctx) begin
                        run_path_s = 1'b1;
                    end else begin
                        issue_s = 1'b1;
                    end
                end
                ST_RUN:  run_path_s = 1'b1;
                default: state_d = ST_REGULAR;
            endcase
            if (run_path_s) begin
                if (s_run_match) begin
                    if (cnt_next_s == thresh_s) begin
                        // Full run segment of 2^J pixels: emit a hit, advance RUNindex.
                        hit_now_s  = 1'b1;
                        issue_s    = 1'b1;
                        cmd_mode_s = MODE_HIT;
                        cmd_j_s    = j_cur_s;
                        cnt_d      = CNT_ZERO;
                        if (idx_q != IDX_MAX) begin
                            idx_d = idx_q + IDX_ONE;
                        end else begin
                            idx_d = idx_q;
                        end
                    end else begin
                        cnt_d = cnt_next_s;
                    end
                    if (s_eol) begin
                        // Line ends inside a run: flush any partial count, keep RUNindex.
                        state_d = ST_REGULAR;
                        cnt_d   = CNT_ZERO;
                        if (!hit_now_s && (cnt_next_s != CNT_ZERO)) begin
                            issue_s    = 1'b1;
                            cmd_mode_s = MODE_EOL;
                            cmd_j_s    = j_cur_s;
                            cmd_rl_s   = cnt_next_s;
                        end else begin
                            cmd_rl_s = CNT_ZERO;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    // Run interrupted: encode the residual count and back RUNindex off.
                    issue_s     = 1'b1;
                    cmd_mode_s  = MODE_INTR;
                    cmd_j_s     = j_cur_s;
                    cmd_jcomp_s = j_cur_s;
                    cmd_rl_s    = cnt_q;
                    cmd_rit_s   = s_RIType;
                    cnt_d       = CNT_ZERO;
                    state_d     = ST_REGULAR;
                    if (idx_q != IDX_ZERO) begin
                        idx_d = idx_q - IDX_ONE;
                    end else begin
                        idx_d = idx_q;
                    end
                end
            end else begin
                state_d = state_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Command register: load a new command, hold an unaccepted one, or go idle.
    always_comb begin
        valid_d = valid_q;
        mode_d  = mode_q;
        hit_d   = hit_q;
        j_d     = j_q;
        jcomp_d = jcomp_q;
        rl_d    = rl_q;
        rit_d   = rit_q;
        dre_d   = dre_q;
        if (frame_start || (!issue_s && !(valid_q && !m_ready))) begin
            valid_d = 1'b0;
            mode_d  = MODE_REGULAR;
            hit_d   = 1'b0;
            j_d     = 4'd0;
            jcomp_d = 4'd0;
            rl_d    = CNT_ZERO;
            rit_d   = 1'b0;
            dre_d   = 1'b0;
        end else if (issue_s) begin
            valid_d = 1'b1;
            mode_d  = cmd_mode_s;
            hit_d   = (cmd_mode_s == MODE_HIT);
            j_d     = cmd_j_s;
            jcomp_d = cmd_jcomp_s;
            rl_d    = cmd_rl_s;
            rit_d   = cmd_rit_s;
            dre_d   = (cmd_mode_s != MODE_REGULAR);
        end else begin
            valid_d = valid_q;
        end
    end

    // State, run bookkeeping and command registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_REGULAR;
            idx_q   <= IDX_ZERO;
            cnt_q   <= CNT_ZERO;
            valid_q <= 1'b0;
            mode_q  <= MODE_REGULAR;
            hit_q   <= 1'b0;
            j_q     <= 4'd0;
            jcomp_q <= 4'd0;
            rl_q    <= CNT_ZERO;
            rit_q   <= 1'b0;
            dre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            mode_q  <= mode_d;
            hit_q   <= hit_d;
            j_q     <= j_d;
            jcomp_q <= jcomp_d;
            rl_q    <= rl_d;
            rit_q   <= rit_d;
            dre_q   <= dre_d;
        end
    end

    assign m_valid         = valid_q;
    assign mode            = mode_q;
    assign hit             = hit_q;
    assign J               = j_q;
    assign J_Comp          = jcomp_q;
    assign run_length      = rl_q;
    assign RIType          = rit_q;
    assign do_run_encoding = dre_q;
    assign run_index       = idx_q;

endmodule

// File: tb/tb_rice_run_scheduler.sv
// Bench for rice_run_scheduler: directed scenarios with literal expectations,
// then randomized traffic, all compared each cycle against a behavioural model.
module tb_rice_run_scheduler;

    logic        clk;
    logic        reset;
    logic        frame_start;
    logic        s_valid;
    logic        s_ready;
    logic        s_run_ctx;
    logic        s_run_match;
    logic        s_eol;
    logic        s_RIType;
    logic        m_valid;
    logic        m_ready;
    logic [1:0]  mode;
    logic        hit;
    logic [3:0]  J;
    logic [3:0]  J_Comp;
    logic [15:0] run_length;
    logic        RIType;
    logic        do_run_encoding;
    logic [4:0]  run_index;

    rice_run_scheduler dut (
        .clk             (clk),
        .reset           (reset),
        .frame_start     (frame_start),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_run_ctx       (s_run_ctx),
        .s_run_match     (s_run_match),
        .s_eol           (s_eol),
        .s_RIType        (s_RIType),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .mode            (mode),
        .hit             (hit),
        .J               (J),
        .J_Comp          (J_Comp),
        .run_length      (run_length),
        .RIType          (RIType),
        .do_run_encoding (do_run_encoding),
        .run_index       (run_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    // Behavioural model state
    int jtab [32] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,4,4,5,5,6,6,7,7,8,9,10,11,12,13,14,15};
    int md_idx = 0;
    int md_cnt = 0;
    bit md_run = 1'b0;
    bit md_acc = 1'b0;
    bit ev     = 1'b0;
    int e_mode = 0;
    int e_j    = 0;
    int e_jc   = 0;
    int e_rl   = 0;
    int e_rit  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic emit(input int m, input int j, input int jc, input int rl, input int rit);
        ev     = 1'b1;
        e_mode = m;
        e_j    = j;
        e_jc   = jc;
        e_rl   = rl;
        e_rit  = rit;
    endtask

    task automatic model_clear();
        md_idx = 0;
        md_cnt = 0;
        md_run = 1'b0;
        ev     = 1'b0;
    endtask

    // One accepted pixel, following the run-mode rules directly.
    task automatic model_pixel();
        int thr;
        bit got_hit;
        got_hit = 1'b0;
        if (!md_run && !s_run_ctx) begin
            emit(0, 0, 0, 0, 0);
        end else if (s_run_match) begin
            thr    = 1 << jtab[md_idx];
            md_cnt = md_cnt + 1;
            if (md_cnt == thr) begin
                emit(1, jtab[md_idx], 0, 0, 0);
                got_hit = 1'b1;
                md_cnt  = 0;
                md_idx  = (md_idx == 31) ? 31 : md_idx + 1;
            end
            if (s_eol) begin
                if (!got_hit && md_cnt > 0) emit(3, jtab[md_idx], 0, md_cnt, 0);
                md_cnt = 0;
                md_run = 1'b0;
            end else begin
                md_run = 1'b1;
            end
        end else begin
            emit(2, jtab[md_idx], jtab[md_idx], md_cnt, int'(s_RIType));
            md_cnt = 0;
            md_idx = (md_idx == 0) ? 0 : md_idx - 1;
            md_run = 1'b0;
        end
    endtask

    // Model advance on each clock edge, cleared asynchronously by reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_clear();
        end else if (frame_start) begin
            model_clear();
        end else begin
            md_acc = s_valid && (!ev || m_ready);
            if (ev && m_ready) ev = 1'b0;
            if (md_acc) model_pixel();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (reset && cmp_en) begin
            chk("m_valid", 32'(m_valid), 32'(ev));
            chk("s_ready", 32'(s_ready), 32'(!ev || m_ready));
            chk("run_index", 32'(run_index), 32'(md_idx));
            if (ev) begin
                chk("mode", 32'(mode), 32'(e_mode));
                chk("hit", 32'(hit), 32'(e_mode == 1));
                chk("J", 32'(J), 32'(e_j));
                chk("J_Comp", 32'(J_Comp), 32'(e_jc));
                chk("run_length", 32'(run_length), 32'(e_rl));
                chk("RIType", 32'(RIType), 32'(e_rit));
                chk("do_run_encoding", 32'(do_run_encoding), 32'(e_mode != 0));
            end
        end
    end

    task automatic pix(input logic ctx, input logic match, input logic eol, input logic rit);
        @(negedge clk);
        #1;
        s_valid     = 1'b1;
        s_run_ctx   = ctx;
        s_run_match = match;
        s_eol       = eol;
        s_RIType    = rit;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    initial begin
        int guard;
        reset       = 1'b0;
        frame_start = 1'b0;
        s_valid     = 1'b0;
        s_run_ctx   = 1'b0;
        s_run_match = 1'b0;
        s_eol       = 1'b0;
        s_RIType    = 1'b0;
        m_ready     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        reset  = 1'b1;
        cmp_en = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_run_index", 32'(run_index), 32'd0);
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);

        // frame_start pulse
        @(negedge clk);
        #1;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;

        // Three hits at J=0
        for (int i = 0; i < 3; i++) begin
            pix(1'b1, 1'b1, 1'b0, 1'b0);
            chk("t1_valid", 32'(m_valid), 32'd1);
            chk("t1_mode", 32'(mode), 32'd1);
            chk("t1_hit", 32'(hit), 32'd1);
            chk("t1_J", 32'(J), 32'd0);
        end
        chk("t1_idx", 32'(run_index), 32'd3);

        // Hit to idx 4, one partial, then interruption
        pix(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t2_hit", 32'(hit), 32'd1);
        chk("t2_idx4", 32'(run_index), 32'd4);
        pix(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t2_nocmd", 32'(m_valid), 32'd0);
        pix(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t2_mode", 32'(mode), 32'd2);
        chk("t2_jcomp", 32'(J_Comp), 32'd1);
        chk("t2_rl", 32'(run_length), 32'd1);
        chk("t2_rit", 32'(RIType), 32'd1);
        chk("t2_idx3", 32'(run_index), 32'd3);

        // Climb to idx 8, then EOL partial run of 3
        repeat (9) pix(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t3_idx8", 32'(run_index), 32'd8);
        pix(1'b1, 1'b1, 1'b0, 1'b0);
        pix(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t3_nocmd", 32'(m_valid), 32'd0);
        pix(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t3_mode", 32'(mode), 32'd3);
        chk("t3_rl", 32'(run_length), 32'd3);
        chk("t3_idx", 32'(run_index), 32'd8);
        pix(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_regular", 32'(mode), 32'd0);
        chk("t3_dre", 32'(do_run_encoding), 32'd0);

        // Back down to idx 4, then hit on the EOL pixel
        repeat (4) pix(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t4_idx4", 32'(run_index), 32'd4);
        pix(1'b1, 1'b1, 1'b0, 1'b0);
        pix(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t4_mode", 32'(mode), 32'd1);
        @(posedge clk);
        #1;
        chk("t4_no_eol_cmd", 32'(m_valid), 32'd0);
        chk("t4_idx5", 32'(run_index), 32'd5);

        // Backpressure on a mode 0 command
        pix(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        m_ready     = 1'b0;
        s_valid     = 1'b1;
        s_run_ctx   = 1'b1;
        s_run_match = 1'b0;
        s_eol       = 1'b0;
        s_RIType    = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("t5_s_ready", 32'(s_ready), 32'd0);
            chk("t5_valid", 32'(m_valid), 32'd1);
            chk("t5_mode", 32'(mode), 32'd0);
        end
        @(negedge clk);
        #1;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("t5_drain_mode", 32'(mode), 32'd2);
        chk("t5_drain_idx", 32'(run_index), 32'd4);

        // Saturate RUNindex at 31
        guard = 0;
        while (md_idx < 31 && guard < 40000) begin
            pix(1'b1, 1'b1, 1'b0, 1'b0);
            guard++;
        end
        chk("t6_idx31", 32'(run_index), 32'd31);
        repeat (32768) pix(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6_sat_mode", 32'(mode), 32'd1);
        chk("t6_sat_J", 32'(J), 32'd15);
        chk("t6_sat_idx", 32'(run_index), 32'd31);

        // Asynchronous reset mid-run
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(m_valid), 32'd0);
        chk("t6_rst_idx", 32'(run_index), 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b1;

        // Randomized traffic
        repeat (3000) begin
            @(negedge clk);
            #1;
            frame_start = ($urandom_range(0, 63) == 0);
            s_valid     = ($urandom_range(0, 3) != 0);
            s_run_ctx   = 1'($urandom_range(0, 1));
            s_run_match = ($urandom_range(0, 7) != 0);
            s_eol       = ($urandom_range(0, 15) == 0);
            s_RIType    = 1'($urandom_range(0, 1));
            m_ready     = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        #1;
        s_valid     = 1'b0;
        frame_start = 1'b0;
        m_ready     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
